// File: rtl/cas_decoder.sv
// Cassette-input decoder: classifies each bit by the width of its low half-cycle and assembles bytes LSB first.
// Optional CAS_DEGLITCH_EN adds a 3-sample majority filter ahead of edge detection (+2 clk latency).
module cas_decoder #(
    parameter logic [23:0] STP        = 24'd22496,
    parameter logic [7:0]  MIN_LOW    = 8'd8,
    parameter logic [7:0]  THRESH     = 8'd24,
    parameter logic [7:0]  MAX_LOW    = 8'd48,
    parameter logic [7:0]  IDLE_TICKS = 8'd64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       din,
    output logic [7:0] dout,
    output logic       valid,
    output logic       bit_stb,
    output logic       bit_val,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t      state_q, state_d, prev_q, prev_d;
    logic        s1_q, s2_q, p_q, s;
    logic [23:0] acc_q, acc_d;
    logic [24:0] sum;
    logic [7:0]  cnt_q, cnt_d, cnt_inc, hcnt_q, hcnt_d;
    logic [2:0]  nbit_q, nbit_d;
    logic [7:0]  sr_q, sr_d, sr_new, dout_q, dout_d;
    logic        valid_q, valid_d, bit_stb_q, bit_stb_d, bit_val_q, bit_val_d, err_q, err_d;
    logic        rise, fall, edge_det, tick, bit_new;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= din;
            s2_q <= s1_q;
        end
    end

`ifdef CAS_DEGLITCH_EN
    logic h1_q, h2_q, maj_q;

    // A lone sample never reaches the two-of-three majority, so single-clk spikes vanish here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h1_q  <= 1'b1;
            h2_q  <= 1'b1;
            maj_q <= 1'b1;
        end else begin
            h1_q  <= s2_q;
            h2_q  <= h1_q;
            maj_q <= (s2_q & h1_q) | (s2_q & h2_q) | (h1_q & h2_q);
        end
    end

    assign s = maj_q;
`else
    assign s = s2_q;
`endif

    assign rise     = s & ~p_q;
    assign fall     = ~s & p_q;
    assign edge_det = rise | fall;
    assign sum      = {1'b0, acc_q} + {1'b0, STP};
    assign tick     = sum[24] & ~edge_det;
    assign acc_d    = (edge_det || !en) ? 24'd0 : sum[23:0];
    assign cnt_inc  = (tick && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        cnt_d     = cnt_inc;
        hcnt_d    = hcnt_q;
        nbit_d    = nbit_q;
        sr_d      = sr_q;
        dout_d    = dout_q;
        valid_d   = 1'b0;
        bit_stb_d = 1'b0;
        bit_val_d = bit_val_q;
        err_d     = 1'b0;
        bit_new   = 1'b0;
        sr_new    = sr_q;
        if (!en) begin
            state_d = IDLE;
            nbit_d  = 3'd0;
            sr_d    = 8'd0;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: if (fall) begin
                    state_d = LOW;
                    prev_d  = IDLE;
                    cnt_d   = 8'd0;
                end
                LOW: if (rise) begin
                    if (cnt_q < MIN_LOW) begin
                        // Glitch: resume the interrupted phase with its high count intact.
                        state_d = prev_q;
                        cnt_d   = hcnt_q;
                    end else if (cnt_q > MAX_LOW) begin
                        err_d   = 1'b1;
                        sr_d    = 8'd0;
                        nbit_d  = 3'd0;
                        state_d = IDLE;
                    end else begin
                        bit_new   = (cnt_q < THRESH);
                        sr_new    = {bit_new, sr_q[7:1]};
                        sr_d      = sr_new;
                        bit_stb_d = 1'b1;
                        bit_val_d = bit_new;
                        nbit_d    = nbit_q + 3'd1;
                        state_d   = HIGH;
                        cnt_d     = 8'd0;
                        if (nbit_q == 3'd7) begin
                            dout_d  = sr_new;
                            valid_d = 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_d = LOW;
                        prev_d  = HIGH;
                        hcnt_d  = cnt_q;
                        cnt_d   = 8'd0;
                    end else if (cnt_q > IDLE_TICKS) begin
                        if (nbit_q != 3'd0) begin
                            err_d  = 1'b1;
                            sr_d   = 8'd0;
                            nbit_d = 3'd0;
                        end
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q       <= 1'b1;
            state_q   <= IDLE;
            prev_q    <= IDLE;
            acc_q     <= 24'd0;
            cnt_q     <= 8'd0;
            hcnt_q    <= 8'd0;
            nbit_q    <= 3'd0;
            sr_q      <= 8'd0;
            dout_q    <= 8'd0;
            valid_q   <= 1'b0;
            bit_stb_q <= 1'b0;
            bit_val_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            p_q       <= s;
            state_q   <= state_d;
            prev_q    <= prev_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hcnt_q    <= hcnt_d;
            nbit_q    <= nbit_d;
            sr_q      <= sr_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            bit_stb_q <= bit_stb_d;
            bit_val_q <= bit_val_d;
            err_q     <= err_d;
        end
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign bit_stb = bit_stb_q;
    assign bit_val = bit_val_q;
    assign err     = err_q;
    assign busy    = (nbit_q != 3'd0);

endmodule

// File: tb/tb_cas_decoder.sv
// Directed bench for cas_decoder: expected bits/bytes/errors are queued as stimulus is sent and matched against observed strobes.
module tb_cas_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b0;
    logic       din = 1'b1;
    logic [7:0] dout;
    logic       valid, bit_stb, bit_val, err, busy;

    cas_decoder #(.STP(24'h400000)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .din(din),
        .dout(dout), .valid(valid), .bit_stb(bit_stb), .bit_val(bit_val),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         exp_bits[$];
    logic [7:0] exp_bytes[$];
    int         err_exp = 0;
    bit         obs_bits[$];
    logic [7:0] obs_bytes[$];
    int         err_seen = 0;
    int         lone_valid = 0;
    int         rd_bit = 0;
    int         rd_byte = 0;
    logic [7:0] msr = 8'd0;
    int         mnbit = 0;

    always @(negedge clk) begin
        if (bit_stb) obs_bits.push_back(bit_val);
        if (valid) obs_bytes.push_back(dout);
        if (err) err_seen++;
        if (valid && !bit_stb) lone_valid++;
    end

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic wait_clk(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(int n);
        din = 1'b1;
        wait_clk(n);
    endtask

    task automatic model_clear();
        msr   = 8'd0;
        mnbit = 0;
    endtask

    // g=1 inserts a 1-clk spike and a 20-clk low glitch inside the high phase.
    task automatic send_bit(bit b, bit g);
        int h;
        h = b ? 64 : 128;
        din = 1'b1;
        if (g) begin
            wait_clk(20);
            din = 1'b0; wait_clk(1);
            din = 1'b1; wait_clk(20);
            din = 1'b0; wait_clk(20);
            din = 1'b1; wait_clk(h - 40);
        end else begin
            wait_clk(h);
        end
        din = 1'b0;
        wait_clk(h);
        exp_bits.push_back(b);
        msr = {b, msr[7:1]};
        mnbit++;
        if (mnbit == 8) begin
            exp_bytes.push_back(msr);
            mnbit = 0;
        end
    endtask

    task automatic send_byte(logic [7:0] v, int gi);
        for (int i = 0; i < 8; i++) send_bit(v[i], i == gi);
    endtask

    task automatic drain(string tag);
        chk({tag, ".nbits"}, 32'(obs_bits.size() - rd_bit), 32'(exp_bits.size()));
        while (exp_bits.size() > 0) begin
            if (rd_bit < obs_bits.size()) begin
                chk({tag, ".bit"}, 32'(obs_bits[rd_bit]), 32'(exp_bits[0]));
                rd_bit++;
            end
            void'(exp_bits.pop_front());
        end
        rd_bit = obs_bits.size();
        chk({tag, ".nbytes"}, 32'(obs_bytes.size() - rd_byte), 32'(exp_bytes.size()));
        while (exp_bytes.size() > 0) begin
            if (rd_byte < obs_bytes.size()) begin
                chk({tag, ".byte"}, 32'(obs_bytes[rd_byte]), 32'(exp_bytes[0]));
                rd_byte++;
            end
            void'(exp_bytes.pop_front());
        end
        rd_byte = obs_bytes.size();
        chk({tag, ".err"}, 32'(err_seen), 32'(err_exp));
    endtask

    initial begin
        wait_clk(3);
        chk("rst.dout", 32'(dout), 32'h0);
        chk("rst.valid", 32'(valid), 32'h0);
        chk("rst.bit_stb", 32'(bit_stb), 32'h0);
        chk("rst.bit_val", 32'(bit_val), 32'h0);
        chk("rst.err", 32'(err), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        en = 1'b1;
        idle(20);

        // single byte
        send_byte(8'hA5, -1);
        chk("a5.busy_mid", 32'(busy), 32'h1);
        idle(20);
        chk("a5.busy_end", 32'(busy), 32'h0);
        chk("a5.dout", 32'(dout), 32'hA5);
        drain("a5");
        idle(300);
        drain("a5_idle");

        // back-to-back bytes
        send_byte(8'h00, -1);
        send_byte(8'hFF, -1);
        send_byte(8'h55, -1);
        idle(20);
        drain("b2b");
        chk("b2b.dout", 32'(dout), 32'h55);

        // high-time timeout mid-byte
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        idle(10);
        chk("tmo.busy_pre", 32'(busy), 32'h1);
        idle(400);
        err_exp++;
        model_clear();
        chk("tmo.busy", 32'(busy), 32'h0);
        drain("tmo");
        send_byte(8'h3C, -1);
        idle(20);
        drain("3c");
        chk("3c.dout", 32'(dout), 32'h3C);

        // glitches inside a high phase
        send_byte(8'h96, 3);
        idle(20);
        drain("glitch");
        chk("glitch.dout", 32'(dout), 32'h96);

        // over-long low phase
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        din = 1'b1; wait_clk(64);
        din = 1'b0; wait_clk(240);
        idle(20);
        err_exp++;
        model_clear();
        chk("long.busy", 32'(busy), 32'h0);
        drain("long");
        send_byte(8'h81, -1);
        idle(20);
        drain("81");
        chk("81.dout", 32'(dout), 32'h81);
        idle(300);

        // asynchronous reset mid-byte
        for (int i = 0; i < 4; i++) send_bit(1'(i & 1), 1'b0);
        idle(10);
        drain("prerst");
        chk("prerst.busy", 32'(busy), 32'h1);
        #3 reset_n = 1'b0;
        #1;
        chk("arst.dout", 32'(dout), 32'h0);
        chk("arst.busy", 32'(busy), 32'h0);
        chk("arst.valid", 32'(valid), 32'h0);
        chk("arst.bit_val", 32'(bit_val), 32'h0);
        model_clear();
        wait_clk(3);
        reset_n = 1'b1;
        idle(10);
        send_byte(8'h7E, -1);
        idle(20);
        drain("7e_a");
        chk("7e_a.dout", 32'(dout), 32'h7E);
        idle(300);

        // enable dropped mid-byte
        for (int i = 0; i < 4; i++) send_bit(1'(~i & 1), 1'b0);
        idle(10);
        drain("preen");
        chk("preen.busy", 32'(busy), 32'h1);
        en = 1'b0;
        wait_clk(5);
        chk("en.busy", 32'(busy), 32'h0);
        wait_clk(300);
        model_clear();
        drain("en");
        chk("en.dout", 32'(dout), 32'h7E);
        en = 1'b1;
        idle(10);
        send_byte(8'h7E, -1);
        idle(20);
        drain("7e_b");
        chk("7e_b.dout", 32'(dout), 32'h7E);

        chk("valid_with_bit_stb", 32'(lone_valid), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
